// File: rtl/cnn_mac_stream_if.sv
// Stream interface for cnn_mac_stream: activation/weight beats in, per-channel results out.
// master drives beats and out_ready; slave is the MAC block.
interface cnn_mac_stream_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int OUT_W  = 16
);
    localparam int CH_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_x;
    logic [N_OUT*DATA_W-1:0]   in_w;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_W-1:0]          out_data;
    logic [CH_W-1:0]           out_ch;
    logic                      out_last;

    modport master (
        output in_valid, in_x, in_w, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );

    modport slave (
        input  in_valid, in_x, in_w, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_last
    );
endinterface

// File: rtl/cnn_mac_stream.sv
// Time-multiplexed MAC: accumulates N_IN beats into N_OUT channels, then drains saturated results serially.
// Optional macro CNN_MAC_STREAM_RELU_EN clamps negative results to zero after saturation.
module cnn_mac_stream #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 16,
    parameter int N_OUT  = 4,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    cnn_mac_stream_if.slave  bus
);
    localparam int CH_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CNT_W = $clog2(N_IN);
    localparam int P_W   = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;

    state_t                 state, next_state;
    logic [CNT_W-1:0]       tap_cnt;
    logic [CH_W-1:0]        out_ch;
    logic                   prod_valid;
    logic signed [P_W-1:0]  prod  [N_OUT];
    logic signed [P_W-1:0]  w_ext [N_OUT];
    logic signed [P_W-1:0]  x_ext;
    logic signed [ACC_W-1:0] acc  [N_OUT];
    logic signed [ACC_W-1:0] sel_acc;
    logic [OUT_W-1:0]       sat_val;
    logic [OUT_W-1:0]       res_val;
    logic                   in_ready_c, out_valid_c;
    logic                   accept, out_fire, last_tap, last_ch;

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (accept && last_tap) next_state = FLUSH;
            FLUSH:   next_state = DRAIN;
            DRAIN:   if (out_fire && last_ch) next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    // in_ready is forced low while reset is asserted, even though the state is already ACCUM
    always_comb begin
        in_ready_c  = (state == ACCUM) && !rst;
        out_valid_c = (state == DRAIN);
    end

    assign accept   = bus.in_valid && in_ready_c;
    assign out_fire = out_valid_c && bus.out_ready;
    assign last_tap = (tap_cnt == CNT_W'(N_IN - 1));
    assign last_ch  = (out_ch == CH_W'(N_OUT - 1));

    // Operands are widened to the product width so the truncated product is exact
    assign x_ext = {{DATA_W{bus.in_x[DATA_W-1]}}, bus.in_x};
    always_comb begin
        for (int c = 0; c < N_OUT; c++) begin
            w_ext[c] = {{DATA_W{bus.in_w[c*DATA_W+DATA_W-1]}}, bus.in_w[c*DATA_W +: DATA_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt    <= '0;
            out_ch     <= '0;
            prod_valid <= 1'b0;
            for (int c = 0; c < N_OUT; c++) begin
                prod[c] <= '0;
                acc[c]  <= '0;
            end
        end else begin
            prod_valid <= accept;
            if (accept) begin
                tap_cnt <= last_tap ? '0 : tap_cnt + CNT_W'(1);
                for (int c = 0; c < N_OUT; c++) begin
                    prod[c] <= x_ext * w_ext[c];
                end
            end
            if (prod_valid) begin
                for (int c = 0; c < N_OUT; c++) begin
                    acc[c] <= acc[c] + {{(ACC_W-P_W){prod[c][P_W-1]}}, prod[c]};
                end
            end
            if (out_fire) begin
                if (last_ch) begin
                    out_ch <= '0;
                    for (int c = 0; c < N_OUT; c++) begin
                        acc[c] <= '0;
                    end
                end else begin
                    out_ch <= out_ch + CH_W'(1);
                end
            end
        end
    end

    always_comb begin
        sel_acc = acc[out_ch];
        if (sel_acc > SAT_MAX)      sat_val = OUT_MAX;
        else if (sel_acc < SAT_MIN) sat_val = OUT_MIN;
        else                        sat_val = sel_acc[OUT_W-1:0];
`ifdef CNN_MAC_STREAM_RELU_EN
        res_val = sat_val[OUT_W-1] ? '0 : sat_val;
`else
        res_val = sat_val;
`endif
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_valid_c ? res_val : '0;
    assign bus.out_ch    = out_ch;
    assign bus.out_last  = out_valid_c && last_ch;
endmodule

// File: tb/tb_cnn_mac_stream.sv
// Directed, table-driven bench for cnn_mac_stream with N_IN=16, N_OUT=4, DATA_W=8, ACC_W=20, OUT_W=16.
// Expected values are hand-computed; the ReLU build is covered by a small clamp on those constants.
module tb_cnn_mac_stream;
    localparam int DATA_W = 8;
    localparam int N_IN   = 16;
    localparam int N_OUT  = 4;
    localparam int ACC_W  = 20;
    localparam int OUT_W  = 16;

    typedef struct {
        string name;
        int    x0;
        int    dx;
        int    w   [N_OUT];
        int    exp [N_OUT];
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    frame_vec_t vecs [5];

    always #5 clk = ~clk;

    cnn_mac_stream_if #(.DATA_W(DATA_W), .N_OUT(N_OUT), .OUT_W(OUT_W)) bus ();

    cnn_mac_stream #(
        .DATA_W(DATA_W), .N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int reluModel(input int v);
`ifdef CNN_MAC_STREAM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic setVec(input int idx, input string name, input int x0, input int dx,
                          input int w0, input int w1, input int w2, input int w3,
                          input int e0, input int e1, input int e2, input int e3);
        vecs[idx].name = name;
        vecs[idx].x0 = x0;
        vecs[idx].dx = dx;
        vecs[idx].w[0] = w0; vecs[idx].w[1] = w1; vecs[idx].w[2] = w2; vecs[idx].w[3] = w3;
        vecs[idx].exp[0] = e0; vecs[idx].exp[1] = e1; vecs[idx].exp[2] = e2; vecs[idx].exp[3] = e3;
    endtask

    // Drives nbeats beats of vector idx; on return the last beat was just accepted at a rising edge
    task automatic applyStimulus(input int idx, input int nbeats, input bit gaps);
        int sent = 0;
        while (sent < nbeats) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_x = 8'(vecs[idx].x0 + vecs[idx].dx * sent);
                for (int c = 0; c < N_OUT; c++) bus.in_w[c*DATA_W +: DATA_W] = 8'(vecs[idx].w[c]);
                sent++;
            end
            @(posedge clk);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " in_ready"},  int'(bus.in_ready), 0);
        checkOutput({tag, " out_valid"}, int'(bus.out_valid), 0);
        checkOutput({tag, " out_data"},  int'(bus.out_data), 0);
        checkOutput({tag, " out_ch"},    int'(bus.out_ch), 0);
        checkOutput({tag, " out_last"},  int'(bus.out_last), 0);
    endtask

    task automatic drainFrame(input int idx, input int stall_ch, input int stall_cycles);
        string n = vecs[idx].name;
        bus.out_ready = 1'b1;
        for (int ch = 0; ch < N_OUT; ch++) begin
            checkOutput($sformatf("%s ch%0d valid", n, ch), int'(bus.out_valid), 1);
            checkOutput($sformatf("%s ch%0d data", n, ch), int'($signed(bus.out_data)), reluModel(vecs[idx].exp[ch]));
            checkOutput($sformatf("%s ch%0d index", n, ch), int'(bus.out_ch), ch);
            checkOutput($sformatf("%s ch%0d last", n, ch), int'(bus.out_last), (ch == N_OUT - 1) ? 1 : 0);
            checkOutput($sformatf("%s ch%0d in_ready", n, ch), int'(bus.in_ready), 0);
            if (ch == stall_ch) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    checkOutput($sformatf("%s stall%0d data", n, s), int'($signed(bus.out_data)), reluModel(vecs[idx].exp[ch]));
                    checkOutput($sformatf("%s stall%0d index", n, s), int'(bus.out_ch), ch);
                    checkOutput($sformatf("%s stall%0d valid", n, s), int'(bus.out_valid), 1);
                    checkOutput($sformatf("%s stall%0d in_ready", n, s), int'(bus.in_ready), 0);
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput({n, " post-drain in_ready"}, int'(bus.in_ready), 1);
        checkOutput({n, " post-drain out_valid"}, int'(bus.out_valid), 0);
        checkOutput({n, " post-drain out_ch"}, int'(bus.out_ch), 0);
    endtask

    task automatic runFrame(input int idx, input bit gaps, input int stall_ch, input int stall_cycles);
        applyStimulus(idx, N_IN, gaps);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput({vecs[idx].name, " flush out_valid"}, int'(bus.out_valid), 0);
        checkOutput({vecs[idx].name, " flush in_ready"}, int'(bus.in_ready), 0);
        @(negedge clk);
        drainFrame(idx, stall_ch, stall_cycles);
    endtask

    initial begin
        setVec(0, "basic",     1,    1, 1,   1,  1,   1,   136,    136,    136,    136);
        setVec(1, "b2b_B",     2,    0, 3,   3,  3,   3,   96,     96,     96,     96);
        setVec(2, "signed",    1,    1, 1,  -1,  1,   1,   136,   -136,    136,    136);
        setVec(3, "sat_pos",   127,  0, 127, 127, 127, 127, 32767, 32767,  32767,  32767);
        setVec(4, "sat_neg",  -128,  0, 127, 127, 127, 127, -32768, -32768, -32768, -32768);

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_w      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        #1;
        checkOutput("reset release in_ready", int'(bus.in_ready), 1);

        // Table frames run back to back, so basic -> b2b_B also proves the accumulators clear
        for (int i = 0; i < 5; i++) begin
            runFrame(i, 1'b0, -1, 0);
        end

        $display("[TB] gaps and output backpressure");
        runFrame(0, 1'b1, 2, 5);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 7, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midreset comb in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        checkResetOutputs("midreset");
        rst = 1'b0;
        #1;
        checkOutput("midreset release in_ready", int'(bus.in_ready), 1);
        runFrame(0, 1'b0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
